// File: rtl/hack_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : hack_mem_arb_pkg
//  Purpose   : Shared types and constants for the QSPI memory arbiter.
//  Revision  : 1.0  initial release
// ============================================================================
package hack_mem_arb_pkg;

    // Arbiter sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Owner of the operation currently in flight
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_CPU  = 2'd2
    } grant_t;

    // Read data returned to the requester when an operation is aborted
    localparam logic [15:0] ABORT_RDATA = 16'h0000;

endpackage : hack_mem_arb_pkg
`default_nettype wire

// File: rtl/hack_qspi_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : hack_qspi_mem_arbiter
//  Purpose   : Shares one QSPI serial-SRAM word controller between a
//              real-time display read port and a CPU read/write port.
//              One op in flight, bounded display bursts, WAIT timeout.
//  Revision  : 1.0  initial release
// ============================================================================
module hack_qspi_mem_arbiter
    import hack_mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int DISP_BURST_MAX = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    // display fetch port (read-only)
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic [DATA_W-1:0] disp_rdata,
    // CPU data port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    // controller side
    output logic              mem_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RUN_W  = $clog2(DISP_BURST_MAX + 1);

    // WAIT ends on the TIMEOUT_CYCLES-th cycle, i.e. when the count shows
    // TIMEOUT_CYCLES-1 completed idle cycles.
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(DISP_BURST_MAX);

    state_t              state;
    grant_t              grant;
    logic [TCNT_W-1:0]   tcnt;
    logic [RUN_W-1:0]    disp_run;

    logic                pick_disp;
    logic                pick_cpu;
    logic                op_end;
    logic [DATA_W-1:0]   resp_data;

    // Arbitration decision and end-of-WAIT result selection
    always_comb begin
        pick_disp = 1'b0;
        pick_cpu  = 1'b0;
        op_end    = 1'b0;
        resp_data = DATA_W'(ABORT_RDATA);
        pick_disp = disp_req && !(cpu_req && (disp_run == RUN_MAX));
        pick_cpu  = !pick_disp && cpu_req;
        // a completion in the expiry cycle still counts as a normal completion
        op_end    = mem_done || (tcnt == TCNT_LAST);
        if (mem_done) begin
            resp_data = mem_rdata;
        end
    end

    assign busy = (state != ST_IDLE);

    // Sequencer with registered controller strobes, acks and read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            grant       <= GNT_NONE;
            tcnt        <= '0;
            disp_run    <= '0;
            disp_ack    <= 1'b0;
            disp_rdata  <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            mem_start   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            disp_ack  <= 1'b0;
            cpu_ack   <= 1'b0;
            mem_start <= 1'b0;
            // a timeout set later in this block overrides the clear
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (pick_disp) begin
                        grant     <= GNT_DISP;
                        mem_we    <= 1'b0;
                        mem_addr  <= disp_addr;
                        mem_wdata <= '0;
                        mem_start <= 1'b1;
                        state     <= ST_ISSUE;
                        if (!cpu_req) begin
                            disp_run <= '0;
                        end else if (disp_run != RUN_MAX) begin
                            disp_run <= disp_run + 1'b1;
                        end
                    end else if (pick_cpu) begin
                        grant     <= GNT_CPU;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        mem_start <= 1'b1;
                        disp_run  <= '0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tcnt  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (op_end) begin
                        if (!mem_done) begin
                            timeout_err <= 1'b1;
                        end
                        if (grant == GNT_DISP) begin
                            disp_ack   <= 1'b1;
                            disp_rdata <= resp_data;
                        end else begin
                            cpu_ack   <= 1'b1;
                            // writes return no data
                            cpu_rdata <= mem_we ? '0 : resp_data;
                        end
                        state <= ST_RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    grant <= GNT_NONE;
                    state <= ST_IDLE;
                end
                default: begin
                    grant <= GNT_NONE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : hack_qspi_mem_arbiter
`default_nettype wire

// File: tb/tb_hack_qspi_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : tb_hack_qspi_mem_arbiter
//  Purpose   : Self-checking bench for hack_qspi_mem_arbiter: directed cases
//              followed by randomized transactions against a
//              transaction-level reference model.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_hack_qspi_mem_arbiter;

    localparam int BURST = 4;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        disp_req;
    logic [15:0] disp_addr;
    logic        disp_ack;
    logic [15:0] disp_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        mem_start;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        timeout_err;
    logic        err_clr;

    // reference model state
    int          run;
    bit          exp_err;
    logic [15:0] exp_drd;
    logic [15:0] exp_crd;

    int vectors    = 0;
    int miscompares = 0;

    hack_qspi_mem_arbiter #(
        .ADDR_W         (16),
        .DATA_W         (16),
        .DISP_BURST_MAX (BURST),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_ack    (disp_ack),
        .disp_rdata  (disp_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .mem_start   (mem_start),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        run     = 0;
        exp_err = 1'b0;
        exp_drd = '0;
        exp_crd = '0;
    endtask

    // One complete arbitration + controller transaction, starting in IDLE.
    // d: WAIT cycle (1-based) in which the controller reports done; 0 or >TMO = withheld.
    task automatic run_op(input bit dreq, input bit creq, input bit cwe,
                          input logic [15:0] caddr, input logic [15:0] cwdata,
                          input logic [15:0] daddr, input logic [15:0] rd,
                          input int d, input bit drop, input bit hold, input bit clr);
        bit          win_d;
        bit          tmo;
        int          k_end;
        logic [15:0] val;
        disp_req  = dreq;
        cpu_req   = creq;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        cpu_wdata = cwdata;
        disp_addr = daddr;
        win_d = dreq && !(creq && run == BURST);
        step();
        check("mem_start", mem_start, 1);
        check("busy", busy, 1);
        check("mem_we", mem_we, win_d ? 1'b0 : cwe);
        check("mem_addr", mem_addr, win_d ? daddr : caddr);
        check("mem_wdata", mem_wdata, win_d ? 16'h0 : cwdata);
        if (win_d) run = creq ? ((run + 1 > BURST) ? BURST : run + 1) : 0;
        else       run = 0;
        step();
        check("start_pulse", mem_start, 0);
        if (drop) begin
            if (win_d) disp_req = 1'b0;
            else       cpu_req  = 1'b0;
        end
        tmo   = !(d >= 1 && d <= TMO);
        k_end = tmo ? TMO : d;
        for (int k = 1; k <= k_end; k++) begin
            mem_done  = (k == d);
            mem_rdata = (k == d) ? rd : 16'($urandom);
            err_clr   = clr && (k == k_end);
            step();
            mem_done = 1'b0;
            err_clr  = 1'b0;
            if (k < k_end) check("early_ack", {disp_ack, cpu_ack}, 0);
        end
        val = tmo ? 16'h0 : rd;
        if (tmo)      exp_err = 1'b1;
        else if (clr) exp_err = 1'b0;
        if (win_d) exp_drd = val;
        else       exp_crd = cwe ? 16'h0 : val;
        check("disp_ack", disp_ack, win_d);
        check("cpu_ack", cpu_ack, !win_d);
        check("disp_rdata", disp_rdata, exp_drd);
        check("cpu_rdata", cpu_rdata, exp_crd);
        check("timeout_err", timeout_err, exp_err);
        check("mem_addr_hold", mem_addr, win_d ? daddr : caddr);
        if (!hold) begin
            disp_req = 1'b0;
            cpu_req  = 1'b0;
        end
        step();
        check("ack_pulse", {disp_ack, cpu_ack}, 0);
        check("idle", busy, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        disp_req  = 1'b0;
        disp_addr = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        err_clr   = 1'b0;
        model_reset();
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_start", mem_start, 0);
        check("rst_acks", {disp_ack, cpu_ack}, 0);
        check("rst_addr", mem_addr, 0);
        reset_n = 1'b1;
        step();
        check("rst_idle", busy, 0);

        // CPU write, done five cycles after mem_start
        run_op(0, 1, 1, 16'h0123, 16'hBEEF, 16'h0, 16'h7777, 5, 0, 0, 0);
        // display read
        run_op(1, 0, 0, 16'h1111, 16'h2222, 16'h4000, 16'h5A5A, 2, 0, 0, 0);
        // both requesting continuously: bounded display bursts
        for (int i = 0; i < 10; i++)
            run_op(1, 1, i[0], 16'h8000 + 16'(i), 16'(i * 3), 16'h4000 + 16'(i),
                   16'($urandom), 1 + (i % 3), 0, 1, 0);
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        // withheld done: timeout, sticky until err_clr
        run_op(0, 1, 0, 16'h0042, 16'h0, 16'h0, 16'hFFFF, 0, 0, 0, 0);
        run_op(1, 0, 0, 16'h0, 16'h0, 16'h0100, 16'h1234, 3, 0, 0, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_err = 1'b0;
        check("err_clr", timeout_err, 0);
        // done on the expiry cycle wins
        run_op(1, 0, 0, 16'h0, 16'h0, 16'h0200, 16'hC0DE, TMO, 0, 0, 0);
        // clear and a new timeout together: set wins
        run_op(0, 1, 0, 16'h0300, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1);

        // reset in the middle of WAIT
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0555;
        step();
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_busy", busy, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_err", timeout_err, 0);
        check("arst_rdata", cpu_rdata, 0);
        cpu_req  = 1'b0;
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        check("arst_noack", {disp_ack, cpu_ack}, 0);
        reset_n = 1'b1;
        step();
        run_op(0, 1, 0, 16'h0555, 16'h0, 16'h0, 16'h3C3C, 4, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            int  sel;
            int  d;
            bit  hold;
            bit  clr;
            sel  = $urandom_range(1, 3);
            d    = $urandom_range(0, 12);
            hold = (sel == 3) && ($urandom_range(0, 1) == 1);
            clr  = (d == 0 || d > TMO) && ($urandom_range(0, 1) == 1);
            run_op(sel[0], sel[1], 1'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom), d, $urandom_range(0, 7) == 0, hold, clr);
            if (hold) begin
                disp_req = 1'b0;
                cpu_req  = 1'b0;
                continue;
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                mem_done = 1'($urandom);
                err_clr  = ($urandom_range(0, 3) == 0);
                step();
                if (err_clr) exp_err = 1'b0;
                mem_done = 1'b0;
                err_clr  = 1'b0;
                check("gap_idle", busy, 0);
                check("gap_acks", {disp_ack, cpu_ack}, 0);
                check("gap_err", timeout_err, exp_err);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_hack_qspi_mem_arbiter
`default_nettype wire
